mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, memory data width.
REQ-003 The block SHALL have these ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- m0_req  in  1  master 0 (CPU) access request.
- m0_we  in  1  master 0 write enable.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 grant pulse.
- m0_rvalid  out  1  master 0 read-data-valid pulse.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata, m1_gnt, m1_rvalid, m1_rdata  same as m0_*, for master 1 (loader/debug).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en.

Function
REQ-004 Masters SHALL hold req, we, addr and wdata stable from req assertion until the edge that samples gnt=1.
REQ-005 The FSM SHALL have three states: IDLE (no access), G0 (m0 access this cycle), G1 (m1 access this cycle).
REQ-006 At each edge, eligible_i SHALL be mi_req AND NOT (current state is Gi), so a grant is never repeated for the same request.
REQ-007 The next state SHALL be the policy winner among the eligible masters (REQ-016/017); if no master is eligible, the next state SHALL be IDLE.
REQ-008 In Gi, mi_gnt and mem_en SHALL be 1, with mem_we, mem_addr and mem_wdata copied from master i's registered request; all these outputs SHALL be registered.
REQ-009 Grant latency SHALL be one cycle: req sampled high at edge N in IDLE gives gnt high from edge N to edge N+1.
REQ-010 For a read granted in cycle N, mi_rvalid SHALL be 1 for exactly cycle N+1, and mi_rdata SHALL equal mem_rdata at that time.
REQ-011 mi_rdata SHALL hold its value until the next mi_rvalid pulse.
REQ-012 A write SHALL produce no rvalid; it completes in its grant cycle.
REQ-013 Back-to-back grants to alternating masters SHALL be allowed: G0 to G1 to G0 gives one access per cycle.
REQ-014 A single master SHALL be granted at most once every two cycles.
REQ-015 In IDLE, mem_en and mem_we SHALL be 0, and mem_addr and mem_wdata SHALL hold their last values.

Configuration
REQ-016 With macro ARB_ROUND_ROBIN_EN defined:
- When both masters are eligible, the master not granted most recently SHALL win.
- The last-winner pointer SHALL reset to 1, so m0 wins the first contention.
REQ-017 Without ARB_ROUND_ROBIN_EN, m0 SHALL always win contention (fixed priority), and no last-winner register SHALL exist.

Reset
REQ-018 When reset=0, the block SHALL immediately set:
- state to IDLE;
- all gnt, rvalid, mem_en and mem_we to 0;
- mem_addr, mem_wdata and all rdata to 0;
- the last-winner pointer to 1.
REQ-019 Reset asserted mid-operation SHALL drop a pending rvalid; no rvalid SHALL follow deassertion.
REQ-020 Arbitration SHALL resume at the first rising edge with reset=1.

Verification
REQ-021 Read: m0 read addr 0x0010, memory holds 0x5A -> m0_gnt one cycle later, m0_rvalid the following cycle, m0_rdata=0x5A.
REQ-022 Write: m1 write 0x0200 data 0xC3 -> exactly one cycle with mem_en=1, mem_we=1, mem_addr=0x0200, mem_wdata=0xC3, m1_gnt=1; no m1_rvalid.
REQ-023 Contention: both masters hold req for 6 cycles from IDLE -> RR build: grants G0,G1,G0,G1...; fixed build: G0,G1,G0,G1 (m1 wins only when m0 is ineligible).
REQ-024 Held req: m0_req held high for 5 cycles with m1 idle -> m0_gnt never high on two consecutive cycles.
REQ-025 Reset mid-read: reset=0 in the cycle after m0_gnt of a read -> m0_rvalid stays 0, and all outputs are 0 within the reset cycle.
REQ-026 Idle: no requests for 10 cycles -> mem_en stays 0 and mem_addr is unchanged.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// Two-master memory bus bundle: master request/grant/read-return
// channels plus the shared memory-side strobe/address/data signals.
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic              m0_req;
   logic              m0_we;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_gnt;
   logic              m0_rvalid;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic              m1_we;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_gnt;
   logic              m1_rvalid;
   logic [DATA_W-1:0] m1_rdata;

   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   // Arbiter side
   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata,
      input  mem_rdata
   );

   // Environment side: requesting masters and the memory
   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata,
      output mem_rdata
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master single-port memory arbiter with registered grant/bus outputs.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is m0 priority.
module mem_bus_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input logic               clk,
   input logic               reset,
   mem_bus_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_G0   = 2'd1,
      S_G1   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_elig0;
   logic              w_elig1;
   logic              w_win1;

   logic              w_gnt0;
   logic              w_gnt1;
   logic              w_mem_we;
   logic [ADDR_W-1:0] w_mem_addr;
   logic [DATA_W-1:0] w_mem_wdata;

   logic              r_gnt0;
   logic              r_gnt1;
   logic              r_mem_en;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;
   logic              r_rv0;
   logic              r_rv1;
   logic [DATA_W-1:0] r_rd0;
   logic [DATA_W-1:0] r_rd1;

`ifdef ARB_ROUND_ROBIN_EN
   // r_last = 1 means m1 won most recently
   logic r_last;

   assign w_win1 = ~r_last;

   // Remember the most recent winner so the other master wins next contention
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last <= 1'b1;
      end else if (w_next == S_G0) begin
         r_last <= 1'b0;
      end else if (w_next == S_G1) begin
         r_last <= 1'b1;
      end
   end
`else
   assign w_win1 = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state: a master being served this cycle may not be re-granted
   always_comb begin
      w_elig0 = bus.m0_req && (r_state != S_G0);
      w_elig1 = bus.m1_req && (r_state != S_G1);
      w_next  = S_IDLE;
      if (w_elig0 && w_elig1) begin
         w_next = w_win1 ? S_G1 : S_G0;
      end else if (w_elig0) begin
         w_next = S_G0;
      end else if (w_elig1) begin
         w_next = S_G1;
      end
   end

   // Output decode from the upcoming state; address/data hold when idle
   always_comb begin
      w_gnt0      = (w_next == S_G0);
      w_gnt1      = (w_next == S_G1);
      w_mem_we    = 1'b0;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      unique case (1'b1)
         w_gnt0: begin
            w_mem_we    = bus.m0_we;
            w_mem_addr  = bus.m0_addr;
            w_mem_wdata = bus.m0_wdata;
         end
         w_gnt1: begin
            w_mem_we    = bus.m1_we;
            w_mem_addr  = bus.m1_addr;
            w_mem_wdata = bus.m1_wdata;
         end
         default: ;
      endcase
   end

   // Registered grant and memory-side outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_gnt0      <= 1'b0;
         r_gnt1      <= 1'b0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_gnt0      <= w_gnt0;
         r_gnt1      <= w_gnt1;
         r_mem_en    <= w_gnt0 | w_gnt1;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
      end
   end

   // Read return: rvalid the cycle after a read grant, data held afterwards
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rv0 <= 1'b0;
         r_rv1 <= 1'b0;
         r_rd0 <= '0;
         r_rd1 <= '0;
      end else begin
         r_rv0 <= r_gnt0 & ~r_mem_we;
         r_rv1 <= r_gnt1 & ~r_mem_we;
         if (r_rv0) begin
            r_rd0 <= bus.mem_rdata;
         end
         if (r_rv1) begin
            r_rd1 <= bus.mem_rdata;
         end
      end
   end

   // Memory data arrives during the rvalid cycle; pass it straight through
   assign bus.m0_rdata  = r_rv0 ? bus.mem_rdata : r_rd0;
   assign bus.m1_rdata  = r_rv1 ? bus.mem_rdata : r_rd1;
   assign bus.m0_rvalid = r_rv0;
   assign bus.m1_rvalid = r_rv1;
   assign bus.m0_gnt    = r_gnt0;
   assign bus.m1_gnt    = r_gnt1;
   assign bus.mem_en    = r_mem_en;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_addr  = r_mem_addr;
   assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios then random traffic,
// checked every cycle against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

   localparam int AW = 16;
   localparam int DW = 8;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   mem_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Master drivers
   logic          req  [2];
   logic          we   [2];
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wdat [2];
   bit            pend [2];
   logic [DW-1:0] mem_rdata;

   assign bus.m0_req    = req[0];
   assign bus.m0_we     = we[0];
   assign bus.m0_addr   = addr[0];
   assign bus.m0_wdata  = wdat[0];
   assign bus.m1_req    = req[1];
   assign bus.m1_we     = we[1];
   assign bus.m1_addr   = addr[1];
   assign bus.m1_wdata  = wdat[1];
   assign bus.mem_rdata = mem_rdata;

   // Environment memory (driven by DUT) and reference memory (model only)
   logic [DW-1:0] mem     [0:65535];
   logic [DW-1:0] ref_mem [0:65535];

   // Reference model: who owns the bus this cycle (-1 none) and what access
   int            g;
   int            prev_g;
   int            last;
   logic          cw;
   logic [AW-1:0] ca;
   logic [DW-1:0] cd;
   logic          erv [2];
   logic [DW-1:0] erd [2];

   int checks = 0;
   int errors = 0;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      g = -1;
      prev_g = -1;
      last = 1;
      cw = 1'b0;
      ca = '0;
      cd = '0;
      for (int m = 0; m < 2; m++) begin
         erv[m] = 1'b0;
         erd[m] = '0;
      end
   endtask

   task automatic check_all();
      chk("m0_gnt",    32'(bus.m0_gnt),    32'(g == 0));
      chk("m1_gnt",    32'(bus.m1_gnt),    32'(g == 1));
      chk("mem_en",    32'(bus.mem_en),    32'(g >= 0));
      chk("mem_we",    32'(bus.mem_we),    32'((g >= 0) && cw));
      chk("mem_addr",  32'(bus.mem_addr),  32'(ca));
      chk("mem_wdata", 32'(bus.mem_wdata), 32'(cd));
      chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(erv[0]));
      chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(erv[1]));
      chk("m0_rdata",  32'(bus.m0_rdata),  32'(erd[0]));
      chk("m1_rdata",  32'(bus.m1_rdata),  32'(erd[1]));
   endtask

   // One clock: predict, advance, play memory, compare
   task automatic step();
      logic          pen;
      logic          pwe;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      bit            b0;
      bit            b1;
      int            w;
      pen = bus.mem_en;
      pwe = bus.mem_we;
      pa  = bus.mem_addr;
      pd  = bus.mem_wdata;
      b0 = req[0] && (g != 0);
      b1 = req[1] && (g != 1);
      if (b0 && b1) w = (RR && last == 0) ? 1 : 0;
      else if (b0)  w = 0;
      else if (b1)  w = 1;
      else          w = -1;
      erv[0] = 1'b0;
      erv[1] = 1'b0;
      if (g >= 0) begin
         if (cw) ref_mem[ca] = cd;
         else begin
            erv[g] = 1'b1;
            erd[g] = ref_mem[ca];
         end
      end
      if (w >= 0) begin
         cw = we[w];
         ca = addr[w];
         cd = wdat[w];
         last = w;
      end
      prev_g = g;
      g = w;
      @(posedge clk);
      #1;
      if (pen && pwe) mem[pa] = pd;
      mem_rdata = (pen && !pwe) ? mem[pa] : DW'($urandom);
      #1;
      check_all();
   endtask

   // Random masters that respect the hold-until-granted rule
   task automatic drive_rand();
      for (int m = 0; m < 2; m++) begin
         if (prev_g == m) pend[m] = 1'b0;
         if (!pend[m]) begin
            if ($urandom_range(0, 2) != 0) begin
               pend[m] = 1'b1;
               req[m]  = 1'b1;
               we[m]   = 1'($urandom_range(0, 1));
               addr[m] = AW'($urandom_range(0, 15));
               wdat[m] = DW'($urandom);
            end else begin
               req[m] = 1'b0;
            end
         end
      end
   endtask

   task automatic idle_masters();
      for (int m = 0; m < 2; m++) begin
         req[m]  = 1'b0;
         we[m]   = 1'b0;
         pend[m] = 1'b0;
      end
   endtask

   initial begin
      logic          pg;
      logic [AW-1:0] held_addr;
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = DW'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[16'h0010]     = 8'h5A;
      ref_mem[16'h0010] = 8'h5A;
      for (int m = 0; m < 2; m++) begin
         addr[m] = '0;
         wdat[m] = '0;
      end
      idle_masters();
      mem_rdata = '0;

      // Reset state
      reset = 1'b0;
      model_reset();
      #1;
      check_all();
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();

      // Read: m0 reads 0x0010 holding 0x5A
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
      step();
      chk("rd_gnt", 32'(bus.m0_gnt), 32'd1);
      step();
      req[0] = 1'b0;
      chk("rd_rvalid", 32'(bus.m0_rvalid), 32'd1);
      chk("rd_rdata", 32'(bus.m0_rdata), 32'h5A);
      step();
      chk("rd_hold", 32'(bus.m0_rdata), 32'h5A);

      // Write: m1 writes 0xC3 to 0x0200
      req[1] = 1'b1; we[1] = 1'b1;
      addr[1] = 16'h0200; wdat[1] = 8'hC3;
      step();
      chk("wr_en", 32'(bus.mem_en), 32'd1);
      chk("wr_we", 32'(bus.mem_we), 32'd1);
      chk("wr_addr", 32'(bus.mem_addr), 32'h0200);
      chk("wr_data", 32'(bus.mem_wdata), 32'hC3);
      chk("wr_gnt", 32'(bus.m1_gnt), 32'd1);
      step();
      req[1] = 1'b0;
      chk("wr_once", 32'(bus.mem_en), 32'd0);
      chk("wr_norv", 32'(bus.m1_rvalid), 32'd0);
      step();
      chk("wr_norv2", 32'(bus.m1_rvalid), 32'd0);

      // Contention: both hold requests from IDLE
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0003;
      req[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'h0004;
      wdat[1] = 8'h77;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("cont_g0", 32'(bus.m0_gnt), 32'(k % 2 == 0));
         chk("cont_g1", 32'(bus.m1_gnt), 32'(k % 2 == 1));
      end
      req[0] = 1'b0;
      step();
      req[1] = 1'b0;
      step();

      // Held request from m0 alone: never granted two cycles running
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0005;
      pg = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("held_gap", 32'(pg && bus.m0_gnt), 32'd0);
         pg = bus.m0_gnt;
      end
      step();
      req[0] = 1'b0;
      step();

      // Idle: bus stays quiet and address holds
      held_addr = ca;
      for (int k = 0; k < 10; k++) begin
         step();
         chk("idle_en", 32'(bus.mem_en), 32'd0);
         chk("idle_addr", 32'(bus.mem_addr), 32'(held_addr));
      end

      // Random traffic
      for (int k = 0; k < 300; k++) begin
         drive_rand();
         step();
      end
      idle_masters();
      step();
      step();

      // Reset mid-read: reset in the cycle after the read grant
      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 16'h0010;
      step();
      chk("rst_gnt", 32'(bus.m0_gnt), 32'd1);
      @(posedge clk);
      #2;
      reset = 1'b0;
      idle_masters();
      model_reset();
      #1;
      chk("rst_rv", 32'(bus.m0_rvalid), 32'd0);
      check_all();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      step();
      chk("rst_norv", 32'(bus.m0_rvalid), 32'd0);

      // Arbitration resumes after reset
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0010;
      step();
      chk("resume_gnt", 32'(bus.m1_gnt), 32'd1);
      step();
      req[1] = 1'b0;
      chk("resume_rd", 32'(bus.m1_rdata), 32'h5A);
      for (int k = 0; k < 100; k++) begin
         drive_rand();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
